// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Purpose  : N-port arbiter between the L1 caches and a single L2/memory
//            port. One L1 request is granted at a time (round-robin or fixed
//            priority). The winner's request is latched for the whole L2
//            transaction, and the L2 completion is returned to that port only.
// Ports    : clk, reset_n      - clock, asynchronous active-high reset
//            req_*             - per-port L1 requests (packed, port i at slice i)
//            rsp_resp          - one-cycle completion pulse to the granted port
//            rsp_rdata         - registered read line (held between reads)
//            mem_*             - L2 request/response interface
//            busy, grant_id    - arbiter activity and latched winner index
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int LINE_W    = 256,
  parameter int ADDR_W    = 32,
  parameter int BE_W      = LINE_W / 8,
  parameter int PRIO_MODE = 0,
  localparam int c_id_w   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
  input  logic [NUM_PORTS*BE_W-1:0]   req_byte_en,
  output logic [NUM_PORTS-1:0]        rsp_resp,
  output logic [LINE_W-1:0]           rsp_rdata,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [LINE_W-1:0]           mem_wdata,
  output logic [BE_W-1:0]             mem_byte_en,
  input  logic                        mem_resp,
  input  logic [LINE_W-1:0]           mem_rdata,
  output logic                        busy,
  output logic [c_id_w-1:0]           grant_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_id_w-1:0]    r_ptr;
  logic [c_id_w-1:0]    r_grant_id;
  logic [ADDR_W-1:0]    r_addr;
  logic [LINE_W-1:0]    r_wdata;
  logic [BE_W-1:0]      r_be;
  logic                 r_mem_read;
  logic                 r_mem_write;
  logic [NUM_PORTS-1:0] r_rsp;
  logic [LINE_W-1:0]    r_rdata;

  logic [NUM_PORTS-1:0] w_req;
  logic                 w_found;
  logic [c_id_w-1:0]    w_win;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [LINE_W-1:0]    w_sel_wdata;
  logic [BE_W-1:0]      w_sel_be;
  logic                 w_sel_wr;
  logic [NUM_PORTS-1:0] w_grant_oh;

  // Winner selection. The first pass looks at indices at or above the
  // round-robin pointer (or every index in fixed-priority mode); the second
  // pass supplies the wrap-around to the lowest requesting index.
  always_comb begin
    w_req   = req_read | req_write;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && w_req[i] && ((PRIO_MODE != 0) || (c_id_w'(i) >= r_ptr))) begin
        w_found = 1'b1;
        w_win   = c_id_w'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && w_req[i]) begin
        w_found = 1'b1;
        w_win   = c_id_w'(i);
      end
    end
  end

  // Request fields of the selected port. A port raising both read and write
  // is treated as a write.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    w_sel_wr    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_win == c_id_w'(i)) begin
        w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata[i*LINE_W +: LINE_W];
        w_sel_be    = req_byte_en[i*BE_W +: BE_W];
        w_sel_wr    = req_write[i];
      end
    end
  end

  always_comb begin
    w_grant_oh = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_grant_oh[i] = (r_grant_id == c_id_w'(i));
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_grant_id  <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rsp       <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant_id  <= w_win;
            r_addr      <= w_sel_addr;
            r_wdata     <= w_sel_wdata;
            r_be        <= w_sel_be;
            r_mem_read  <= ~w_sel_wr;
            r_mem_write <= w_sel_wr;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Requests are not looked at here: the latched transaction runs
          // to completion regardless of what the requestor does meanwhile.
          if (mem_resp) begin
            if (r_mem_read) begin
              r_rdata <= mem_rdata;
            end
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_rsp       <= w_grant_oh;
            r_state     <= RESPOND;
          end
        end
        RESPOND: begin
          r_rsp   <= '0;
          r_ptr   <= (r_grant_id == c_id_w'(NUM_PORTS - 1)) ? '0
                                                            : r_grant_id + c_id_w'(1);
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rsp_resp    = r_rsp;
  assign rsp_rdata   = r_rdata;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign mem_byte_en = r_be;
  assign busy        = (r_state != IDLE);
  assign grant_id    = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_mem_arbiter
// Purpose  : Self-checking bench for cache_mem_arbiter. Two 4-port instances
//            (round-robin and fixed priority) are driven by random requestors
//            and a random-latency L2 model. A reference model predicts each
//            grant from the request set seen by the arbiter, pushes the
//            expected completion into a queue, and a monitor pops it when
//            rsp_resp fires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

  localparam int N  = 4;
  localparam int LW = 256;
  localparam int AW = 32;
  localparam int BW = LW / 8;
  localparam int IW = 2;

  typedef struct {
    int port;
    bit wr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input int env, input string name,
                       input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL env%0d %s: actual %0h required %0h", env, name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Arbitration rule: fixed priority takes the lowest requesting index;
  // round-robin takes the first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int ptr, input int pm);
    int p;
    for (int o = 0; o < N; o++) begin
      p = (pm != 0) ? o : (ptr + o) % N;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  for (genvar e = 0; e < 2; e++) begin : g_env
    logic            rst;
    logic [N-1:0]    req_read, req_write, rsp_resp;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_wdata;
    logic [N*BW-1:0] req_be;
    logic [LW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
    logic            mem_read, mem_write, mem_resp, busy;
    logic [AW-1:0]   mem_addr;
    logic [BW-1:0]   mem_be;
    logic [IW-1:0]   grant_id;
    logic [N-1:0]    mask;
    int              prob;
    bit              chaos;
    bit              fin = 1'b0;

    // Values the arbiter saw at the last rising edge.
    logic [N-1:0]    s_rd, s_wr;
    logic [N*AW-1:0] s_addr;
    logic [N*LW-1:0] s_wdata;
    logic [N*BW-1:0] s_be;
    logic            s_resp, s_rst;
    logic [LW-1:0]   s_rdata;

    cache_mem_arbiter #(
      .NUM_PORTS(N), .LINE_W(LW), .ADDR_W(AW), .BE_W(BW), .PRIO_MODE(e)
    ) u_dut (
      .clk(clk), .reset_n(rst),
      .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_byte_en(req_be),
      .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_byte_en(mem_be),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .busy(busy), .grant_id(grant_id)
    );

    always @(posedge clk) begin
      s_rd    <= req_read;
      s_wr    <= req_write;
      s_addr  <= req_addr;
      s_wdata <= req_wdata;
      s_be    <= req_be;
      s_resp  <= mem_resp;
      s_rdata <= mem_rdata;
      s_rst   <= rst;
    end

    // Requestors: raise random requests, drop on completion, and in the
    // chaos phase occasionally drop or alter a pending request.
    initial begin : p_agents
      int k;
      req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_be = '0;
      forever begin
        @(negedge clk);
        for (int p = 0; p < N; p++) begin
          if (rsp_resp[p]) begin
            req_read[p]  = 1'b0;
            req_write[p] = 1'b0;
          end else if (!(req_read[p] || req_write[p])) begin
            if (mask[p] && ($urandom_range(0, 99) < prob)) begin
              k = $urandom_range(0, 7);
              req_write[p] = (k >= 4);
              req_read[p]  = (k < 4) || (k == 7);
              req_addr[p*AW +: AW]  = $urandom;
              req_wdata[p*LW +: LW] = rand_line();
              req_be[p*BW +: BW]    = $urandom;
            end
          end else if (chaos && ($urandom_range(0, 15) == 0)) begin
            if ($urandom_range(0, 1) == 1) begin
              req_read[p]  = 1'b0;
              req_write[p] = 1'b0;
            end else begin
              req_addr[p*AW +: AW] = $urandom;
            end
          end
        end
      end
    end

    // L2 model: answers each access after a random 1..4 cycle delay.
    initial begin : p_mem
      int wl;
      mem_resp = 1'b0; mem_rdata = '0; wl = -1;
      forever begin
        @(negedge clk);
        mem_resp = 1'b0;
        if (rst || !(mem_read || mem_write)) begin
          wl = -1;
        end else begin
          if (wl < 0) wl = $urandom_range(0, 3);
          if (wl == 0) begin
            mem_resp  = 1'b1;
            mem_rdata = rand_line();
            wl = 99;
          end else if (wl != 99) begin
            wl--;
          end
        end
      end
    end

    // Reference model and monitor. mph: 0 arbiter free, 1 transaction
    // outstanding, 2 completion just delivered (arbiter idles one cycle).
    initial begin : p_mon
      exp_t q[$];
      exp_t it;
      int mph, mph_in, ptr, last_port, w;
      bit due;
      logic [LW-1:0] last_rdata, e_wdata;
      logic [AW-1:0] e_addr;
      logic [BW-1:0] e_be;
      logic e_wr;
      mph = 0; ptr = 0; last_port = 0; last_rdata = '0;
      e_wr = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          q.delete();
          mph = 0; ptr = 0; last_port = 0; last_rdata = '0;
        end else begin
          mph_in = mph;
          due = (mph_in == 1) && s_resp && !s_rst;
          if (due && !e_wr) last_rdata = s_rdata;
          if ((rsp_resp != '0) || due) begin
            if (q.size() == 0) begin
              check(e, "rsp_spurious", LW'(rsp_resp), '0);
            end else begin
              it = q.pop_front();
              check(e, "rsp_timing", LW'(due), LW'(1'b1));
              check(e, "rsp_port", LW'(rsp_resp), LW'(4'b0001 << it.port));
              check(e, "rsp_rdata", rsp_rdata, last_rdata);
              ptr = (it.port + 1) % N;
              mph = 2;
            end
          end
          case (mph_in)
            0: begin
              w = s_rst ? -1 : pick(s_rd | s_wr, ptr, e);
              if (w < 0) begin
                check(e, "idle_quiet", LW'({mem_read, mem_write, busy}), '0);
                check(e, "grant_hold", LW'(grant_id), LW'(last_port));
              end else begin
                e_wr    = s_wr[w];
                e_addr  = s_addr[w*AW +: AW];
                e_wdata = s_wdata[w*LW +: LW];
                e_be    = s_be[w*BW +: BW];
                q.push_back('{port: w, wr: e_wr});
                check(e, "grant_id", LW'(grant_id), LW'(w));
                check(e, "mem_op", LW'({mem_read, mem_write, busy}),
                      LW'({~e_wr, e_wr, 1'b1}));
                check(e, "mem_addr", LW'(mem_addr), LW'(e_addr));
                check(e, "mem_wdata", mem_wdata, e_wdata);
                check(e, "mem_byte_en", LW'(mem_be), LW'(e_be));
                last_port = w;
                mph = 1;
              end
            end
            1: begin
              if (due) begin
                check(e, "respond_state", LW'({mem_read, mem_write, busy}), LW'(3'b001));
              end else begin
                check(e, "hold_ctl", LW'({mem_read, mem_write, busy, mem_addr, mem_be}),
                      LW'({~e_wr, e_wr, 1'b1, e_addr, e_be}));
                check(e, "hold_wdata", mem_wdata, e_wdata);
              end
            end
            default: begin
              check(e, "back_to_idle", LW'({mem_read, mem_write, busy}), '0);
              check(e, "grant_hold", LW'(grant_id), LW'(last_port));
              mph = 0;
            end
          endcase
        end
      end
    end

    // Phase sequencing for this instance.
    initial begin : p_ctl
      int i;
      rst = 1'b1; mask = '0; prob = 0; chaos = 1'b0;
      repeat (3) @(negedge clk);
      check(e, "rst_mem", LW'({mem_read, mem_write, busy, mem_addr, mem_be}), '0);
      check(e, "rst_rsp", LW'({rsp_resp, grant_id}), '0);
      check(e, "rst_rdata", rsp_rdata, '0);
      check(e, "rst_wdata", mem_wdata, '0);
      rst = 1'b0;
      // All ports (round-robin) or ports 1 and 2 (fixed priority) saturating.
      mask = (e == 0) ? 4'b1111 : 4'b0110;
      prob = 100;
      repeat (60) @(negedge clk);
      // Port 1 stops re-requesting, so port 2 must now get through.
      mask = 4'b0100;
      repeat (20) @(negedge clk);
      mask = 4'b1111; prob = 30; chaos = 1'b1;
      repeat (1500) @(negedge clk);
      chaos = 1'b0; prob = 100;
      i = 0;
      while (!(mem_read || mem_write) && (i < 50)) begin
        @(negedge clk);
        i++;
      end
      check(e, "issue_reached", LW'(mem_read || mem_write), LW'(1'b1));
      rst = 1'b1;
      #1;
      check(e, "async_rst_mem", LW'({mem_read, mem_write, busy}), '0);
      check(e, "async_rst_rsp", LW'({rsp_resp, grant_id}), '0);
      check(e, "async_rst_rdata", rsp_rdata, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      mask = '0;
      repeat (30) @(negedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    fork
      wait (g_env[0].fin && g_env[1].fin);
      begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog: actual not-finished required finished");
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
